// File: rtl/tripledes_decrypt_seq.sv
// rtl/tripledes_decrypt_seq.sv - sequential 3DES decrypt (D-E-D) that reuses one des core
// des is a purely combinational single-DES; the FSM gives it PASS_WAIT cycles per pass.

module des (
  input  logic [63:0] in,
  input  logic [55:0] k,
  input  logic        e,
  output logic [63:0] out
);

  // Tables hold 1-based FIPS bit numbers (bit 1 = MSB), first entry in the top byte.
  localparam logic [511:0] IP_TAB = {
    8'd58, 8'd50, 8'd42, 8'd34, 8'd26, 8'd18, 8'd10, 8'd2,
    8'd60, 8'd52, 8'd44, 8'd36, 8'd28, 8'd20, 8'd12, 8'd4,
    8'd62, 8'd54, 8'd46, 8'd38, 8'd30, 8'd22, 8'd14, 8'd6,
    8'd64, 8'd56, 8'd48, 8'd40, 8'd32, 8'd24, 8'd16, 8'd8,
    8'd57, 8'd49, 8'd41, 8'd33, 8'd25, 8'd17, 8'd9,  8'd1,
    8'd59, 8'd51, 8'd43, 8'd35, 8'd27, 8'd19, 8'd11, 8'd3,
    8'd61, 8'd53, 8'd45, 8'd37, 8'd29, 8'd21, 8'd13, 8'd5,
    8'd63, 8'd55, 8'd47, 8'd39, 8'd31, 8'd23, 8'd15, 8'd7
  };

  localparam logic [511:0] FP_TAB = {
    8'd40, 8'd8, 8'd48, 8'd16, 8'd56, 8'd24, 8'd64, 8'd32,
    8'd39, 8'd7, 8'd47, 8'd15, 8'd55, 8'd23, 8'd63, 8'd31,
    8'd38, 8'd6, 8'd46, 8'd14, 8'd54, 8'd22, 8'd62, 8'd30,
    8'd37, 8'd5, 8'd45, 8'd13, 8'd53, 8'd21, 8'd61, 8'd29,
    8'd36, 8'd4, 8'd44, 8'd12, 8'd52, 8'd20, 8'd60, 8'd28,
    8'd35, 8'd3, 8'd43, 8'd11, 8'd51, 8'd19, 8'd59, 8'd27,
    8'd34, 8'd2, 8'd42, 8'd10, 8'd50, 8'd18, 8'd58, 8'd26,
    8'd33, 8'd1, 8'd41, 8'd9,  8'd49, 8'd17, 8'd57, 8'd25
  };

  localparam logic [511:0] E_TAB = {
    8'd32, 8'd1,  8'd2,  8'd3,  8'd4,  8'd5,  8'd4,  8'd5,
    8'd6,  8'd7,  8'd8,  8'd9,  8'd8,  8'd9,  8'd10, 8'd11,
    8'd12, 8'd13, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17,
    8'd16, 8'd17, 8'd18, 8'd19, 8'd20, 8'd21, 8'd20, 8'd21,
    8'd22, 8'd23, 8'd24, 8'd25, 8'd24, 8'd25, 8'd26, 8'd27,
    8'd28, 8'd29, 8'd28, 8'd29, 8'd30, 8'd31, 8'd32, 8'd1,
    128'b0
  };

  localparam logic [511:0] P_TAB = {
    8'd16, 8'd7,  8'd20, 8'd21, 8'd29, 8'd12, 8'd28, 8'd17,
    8'd1,  8'd15, 8'd23, 8'd26, 8'd5,  8'd18, 8'd31, 8'd10,
    8'd2,  8'd8,  8'd24, 8'd14, 8'd32, 8'd27, 8'd3,  8'd9,
    8'd19, 8'd13, 8'd30, 8'd6,  8'd22, 8'd11, 8'd4,  8'd25,
    256'b0
  };

  localparam logic [511:0] PC2_TAB = {
    8'd14, 8'd17, 8'd11, 8'd24, 8'd1,  8'd5,  8'd3,  8'd28,
    8'd15, 8'd6,  8'd21, 8'd10, 8'd23, 8'd19, 8'd12, 8'd4,
    8'd26, 8'd8,  8'd16, 8'd7,  8'd27, 8'd20, 8'd13, 8'd2,
    8'd41, 8'd52, 8'd31, 8'd37, 8'd47, 8'd55, 8'd30, 8'd40,
    8'd51, 8'd45, 8'd33, 8'd48, 8'd44, 8'd49, 8'd39, 8'd56,
    8'd34, 8'd53, 8'd46, 8'd42, 8'd50, 8'd36, 8'd29, 8'd32,
    128'b0
  };

  // Nibble index = {box[2:0], row[1:0], col[3:0]}, box 1 in the top 256 bits.
  localparam logic [2047:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  // Source and result are left-aligned in 64 bits; only the first n entries are used.
  function automatic logic [63:0] permute(input logic [63:0] src, input logic [511:0] tab,
                                          input int n);
    logic [63:0] res;
    logic [7:0]  pos;
    res = '0;
    for (int i = 0; i < 64; i++) begin
      pos = tab[511 - 8*i -: 8];
      if (i < n) res[63 - i] = src[6'(8'd64 - pos)];
    end
    return res;
  endfunction

  function automatic logic [31:0] feistel(input logic [31:0] r, input logic [47:0] sk);
    logic [63:0] t;
    logic [47:0] x;
    logic [31:0] s;
    logic [5:0]  b;
    logic [8:0]  idx;
    t = permute({r, 32'b0}, E_TAB, 48);
    x = t[63:16] ^ sk;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      b   = x[47 - 6*i -: 6];
      idx = {3'(i), b[5], b[0], b[4:1]};
      s[31 - 4*i -: 4] = SBOX[2047 - 4*idx -: 4];
    end
    t = permute({s, 32'b0}, P_TAB, 32);
    return t[63:32];
  endfunction

  function automatic logic [63:0] des_core(input logic [63:0] blk, input logic [55:0] key,
                                           input logic enc);
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] ks [16];
    logic [63:0] t;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] nl;
    c = key[55:28];
    d = key[27:0];
    // Rounds 1, 2, 9 and 16 rotate by one; the rest by two.
    for (int j = 0; j < 16; j++) begin
      c = {c[26:0], c[27]};
      d = {d[26:0], d[27]};
      if (!(j == 0 || j == 1 || j == 8 || j == 15)) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      t = permute({c, d, 8'b0}, PC2_TAB, 48);
      ks[j] = t[63:16];
    end
    t = permute(blk, IP_TAB, 64);
    l = t[63:32];
    r = t[31:0];
    for (int j = 0; j < 16; j++) begin
      nl = r;
      r  = l ^ feistel(r, enc ? ks[j] : ks[15 - j]);
      l  = nl;
    end
    return permute({r, l}, FP_TAB, 64);
  endfunction

  always_comb begin
    out = des_core(in, k, e);
  end

endmodule

module tripledes_decrypt_seq #(
  parameter int unsigned PASS_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [55:0] key1,
  input  logic [55:0] key2,
  input  logic [63:0] ciphertext,
  output logic [63:0] plaintext,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    PASS3 = 2'd3
  } state_e;

  localparam logic [3:0] LAST_CNT = 4'(PASS_WAIT - 1);

  state_e      state_q;
  logic [3:0]  wait_cnt_q;
  logic [63:0] data_q;
  logic [55:0] key1_q;
  logic [55:0] key2_q;
  logic [63:0] plaintext_q;
  logic        busy_q;
  logic        done_q;

  logic [63:0] des_out;
  logic [55:0] des_key;
  logic        des_enc;

  // The des inputs come only from registers, so the core is a clean multicycle path.
  assign des_key = (state_q == PASS2) ? key2_q : key1_q;
  assign des_enc = (state_q == PASS2);

  des u_des (
    .in  (data_q),
    .k   (des_key),
    .e   (des_enc),
    .out (des_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wait_cnt_q  <= '0;
      data_q      <= '0;
      key1_q      <= '0;
      key2_q      <= '0;
      plaintext_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            data_q     <= ciphertext;
            key1_q     <= key1;
            key2_q     <= key2;
            wait_cnt_q <= '0;
            state_q    <= PASS1;
            busy_q     <= 1'b1;
          end
        end
        default: begin
          if (wait_cnt_q == LAST_CNT) begin
            wait_cnt_q <= '0;
            data_q     <= des_out;
            case (state_q)
              PASS1:   state_q <= PASS2;
              PASS2:   state_q <= PASS3;
              default: begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                done_q      <= 1'b1;
                plaintext_q <= des_out;
              end
            endcase
          end else begin
            wait_cnt_q <= wait_cnt_q + 4'd1;
          end
        end
      endcase
    end
  end

  assign plaintext = plaintext_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_tripledes_decrypt_seq.sv
// tb/tb_tripledes_decrypt_seq.sv - randomized bench for tripledes_decrypt_seq against a bit-level DES model
module tb_tripledes_decrypt_seq;

  localparam int IP_T [64] = '{58,50,42,34,26,18,10,2, 60,52,44,36,28,20,12,4,
                               62,54,46,38,30,22,14,6, 64,56,48,40,32,24,16,8,
                               57,49,41,33,25,17,9,1,  59,51,43,35,27,19,11,3,
                               61,53,45,37,29,21,13,5, 63,55,47,39,31,23,15,7};
  localparam int FP_T [64] = '{40,8,48,16,56,24,64,32, 39,7,47,15,55,23,63,31,
                               38,6,46,14,54,22,62,30, 37,5,45,13,53,21,61,29,
                               36,4,44,12,52,20,60,28, 35,3,43,11,51,19,59,27,
                               34,2,42,10,50,18,58,26, 33,1,41,9,49,17,57,25};
  localparam int E_T [48] = '{32,1,2,3,4,5, 4,5,6,7,8,9, 8,9,10,11,12,13, 12,13,14,15,16,17,
                              16,17,18,19,20,21, 20,21,22,23,24,25, 24,25,26,27,28,29,
                              28,29,30,31,32,1};
  localparam int P_T [32] = '{16,7,20,21, 29,12,28,17, 1,15,23,26, 5,18,31,10,
                              2,8,24,14, 32,27,3,9, 19,13,30,6, 22,11,4,25};
  localparam int PC2_T [48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8,
                                16,7,27,20,13,2, 41,52,31,37,47,55, 30,40,51,45,33,48,
                                44,49,39,56,34,53, 46,42,50,36,29,32};
  localparam int ROT_T [16] = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};
  localparam logic [63:0] SB_T [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start1;
  logic        start3;
  logic [55:0] key1;
  logic [55:0] key2;
  logic [63:0] ciphertext;
  logic [63:0] pt1;
  logic [63:0] pt3;
  logic        busy1;
  logic        busy3;
  logic        done1;
  logic        done3;

  int n_tests = 0;
  int n_fail  = 0;
  int sel_pw  = 1;

  logic        busy_s;
  logic        done_s;
  logic [63:0] pt_s;
  assign busy_s = (sel_pw == 3) ? busy3 : busy1;
  assign done_s = (sel_pw == 3) ? done3 : done1;
  assign pt_s   = (sel_pw == 3) ? pt3   : pt1;

  tripledes_decrypt_seq #(.PASS_WAIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .key1(key1), .key2(key2),
    .ciphertext(ciphertext), .plaintext(pt1), .busy(busy1), .done(done1));

  tripledes_decrypt_seq #(.PASS_WAIT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .key1(key1), .key2(key2),
    .ciphertext(ciphertext), .plaintext(pt3), .busy(busy3), .done(done3));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bit n (1-based, MSB first) of a w-bit value held in the low bits of v.
  function automatic logic nth(input logic [63:0] v, input int w, input int n);
    logic [63:0] sh;
    sh = v >> (w - n);
    return sh[0];
  endfunction

  function automatic logic [63:0] des_ref(input logic [63:0] blk, input logic [55:0] key,
                                          input bit enc);
    logic [27:0] c;
    logic [27:0] d;
    logic [47:0] ks [16];
    logic [63:0] x;
    logic [63:0] res;
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] f;
    logic [31:0] s;
    logic [47:0] ex;
    logic [5:0]  six;
    int rw;
    int cl;
    c = key[55:28];
    d = key[27:0];
    for (int i = 0; i < 16; i++) begin
      for (int n = 0; n < ROT_T[i]; n++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      ks[i] = '0;
      for (int j = 1; j <= 48; j++) ks[i] = {ks[i][46:0], nth({8'b0, c, d}, 56, PC2_T[j-1])};
    end
    x = '0;
    for (int j = 1; j <= 64; j++) x = {x[62:0], nth(blk, 64, IP_T[j-1])};
    l = x[63:32];
    r = x[31:0];
    for (int i = 0; i < 16; i++) begin
      ex = '0;
      for (int j = 1; j <= 48; j++) ex = {ex[46:0], nth({32'b0, r}, 32, E_T[j-1])};
      ex = ex ^ (enc ? ks[i] : ks[15-i]);
      s = '0;
      for (int b = 0; b < 8; b++) begin
        six = ex[47:42];
        ex  = ex << 6;
        rw  = int'({six[5], six[0]});
        cl  = int'(six[4:1]);
        s   = {s[27:0], 4'(SB_T[b*4 + rw] >> (4*(15 - cl)))};
      end
      f = '0;
      for (int j = 1; j <= 32; j++) f = {f[30:0], nth({32'b0, s}, 32, P_T[j-1])};
      {l, r} = {r, l ^ f};
    end
    x = {r, l};
    res = '0;
    for (int j = 1; j <= 64; j++) res = {res[62:0], nth(x, 64, FP_T[j-1])};
    return res;
  endfunction

  function automatic logic [63:0] tdes_enc(input logic [63:0] p, input logic [55:0] k1,
                                           input logic [55:0] k2);
    return des_ref(des_ref(des_ref(p, k1, 1'b1), k2, 1'b0), k1, 1'b1);
  endfunction

  function automatic logic [63:0] tdes_dec(input logic [63:0] ct, input logic [55:0] k1,
                                           input logic [55:0] k2);
    return des_ref(des_ref(des_ref(ct, k1, 1'b0), k2, 1'b1), k1, 1'b0);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // mode 0: plain pulse; 1: start held high through the block; 2: noise on inputs while busy.
  task automatic run_block(input int pw, input logic [63:0] ct, input logic [55:0] k1,
                           input logic [55:0] k2, input logic [63:0] exp, input int mode);
    int lat;
    bit bad;
    sel_pw     = pw;
    lat        = 3*pw + 1;
    bad        = 0;
    ciphertext = ct;
    key1       = k1;
    key2       = k2;
    if (pw == 3) start3 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        if (busy_s !== 1'b1 || done_s !== 1'b0) bad = 1;
        if (mode == 2) begin
          ciphertext = rand64();
          key1       = 56'(rand64());
          key2       = 56'(rand64());
          if (pw == 3) start3 = 1'($urandom_range(0, 1)); else start1 = 1'($urandom_range(0, 1));
        end else if (mode == 0) begin
          start1 = 1'b0;
          start3 = 1'b0;
        end
        @(posedge clk); #1;
      end else begin
        if (mode != 1) begin
          start1 = 1'b0;
          start3 = 1'b0;
        end
        check("busy_window", 64'(bad), 64'd0);
        check("done_pulse", 64'(done_s), 64'd1);
        check("busy_at_done", 64'(busy_s), 64'd0);
        check("plaintext", pt_s, exp);
      end
    end
  endtask

  initial begin : main
    logic [55:0] ka;
    logic [55:0] kb;
    logic [63:0] p;
    logic [63:0] ct;
    bit bad;

    rst_n      = 1'b0;
    start1     = 1'b0;
    start3     = 1'b0;
    key1       = '0;
    key2       = '0;
    ciphertext = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("idle_pt1", pt1, 64'd0);
      check("idle_busy1", 64'(busy1), 64'd0);
      check("idle_done1", 64'(done1), 64'd0);
      check("idle_pt3", pt3, 64'd0);
      check("idle_busy3", 64'(busy3), 64'd0);
      check("idle_done3", 64'(done3), 64'd0);
      @(posedge clk); #1;
    end

    check("ref_kat", des_ref(64'h0123456789ABCDEF, 56'hF0CCAAF556678F, 1'b1),
          64'h85E813540F0AB405);
    run_block(1, 64'h85E813540F0AB405, 56'hF0CCAAF556678F, 56'hF0CCAAF556678F,
              64'h0123456789ABCDEF, 0);
    check("kat_dut", pt1, 64'h0123456789ABCDEF);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done1), 64'd0);

    for (int i = 0; i < 100; i++) begin
      ka = 56'(rand64());
      kb = 56'(rand64());
      if (ka == kb) kb = ~kb;
      p  = rand64();
      run_block(1, tdes_enc(p, ka, kb), ka, kb, p, 0);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end

    for (int i = 0; i < 30; i++) begin
      ka = 56'(rand64());
      kb = ~ka;
      p  = rand64();
      run_block(3, tdes_enc(p, ka, kb), ka, kb, p, 0);
    end

    for (int i = 0; i < 8; i++) begin
      ka = 56'(rand64());
      kb = 56'(rand64());
      ct = rand64();
      run_block(1, ct, ka, kb, tdes_dec(ct, ka, kb), 1);
    end
    start1 = 1'b0;
    @(posedge clk); #1;
    check("hold_release_idle", 64'(busy1), 64'd0);

    for (int i = 0; i < 12; i++) begin
      ka = 56'(rand64());
      kb = 56'(rand64());
      ct = rand64();
      run_block((i % 3 == 0) ? 3 : 1, ct, ka, kb, tdes_dec(ct, ka, kb), 2);
    end
    @(posedge clk); #1;

    sel_pw     = 1;
    ciphertext = rand64();
    key1       = 56'(rand64());
    key2       = 56'(rand64());
    start1     = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("abort_busy", 64'(busy1), 64'd0);
    check("abort_pt", pt1, 64'd0);
    check("abort_done", 64'(done1), 64'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done1 !== 1'b0 || busy1 !== 1'b0) bad = 1;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    ka = 56'(rand64());
    kb = 56'(rand64());
    p  = rand64();
    run_block(1, tdes_enc(p, ka, kb), ka, kb, p, 0);

    @(posedge clk); #1;
    rst_n  = 1'b0;
    start1 = 1'b1;
    start3 = 1'b1;
    @(posedge clk); #1;
    rst_n  = 1'b1;
    start1 = 1'b0;
    start3 = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy1 !== 1'b0 || busy3 !== 1'b0 || done1 !== 1'b0) bad = 1;
      @(posedge clk); #1;
    end
    check("reset_beats_start", 64'(bad), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tripledes_decrypt_seq.md
# tripledes_decrypt_seq

Sequential triple-DES decryption engine: the receive-side counterpart of the `tripledes` encrypt top. It accepts one 64-bit ciphertext block plus the two-key bundle (key1, key2) and produces the plaintext via D(key1) → E(key2) → D(key1). A single `des` instance is reused for all three passes under an FSM, so one instance is time-shared rather than three being chained. A start/busy/done handshake lets the link controller feed it one block at a time.

## Interface
- `PASS_WAIT`, default 1: cycles allotted per `des` pass, allowing a multicycle path through the combinational `des`. Legal range is 1–15.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `start` input 1: request to decrypt. Sampled only in IDLE.
- `key1` input 56: key for passes 1 and 3, in the 56-bit format `des.k` consumes. Latched at start.
- `key2` input 56: key for pass 2. Latched at start.
- `ciphertext` input 64: block to decrypt. Latched at start.
- `plaintext` output 64: registered result. Holds until the next completion or reset.
- `busy` output 1: high while a block is in flight.
- `done` output 1: one-cycle pulse when `plaintext` updates.

## Operation
- One `des` instance drives all passes:
  - `in` = `data_r`.
  - `k` = `key2_r` in PASS2, otherwise `key1_r`.
  - `e` = 1 in PASS2 (encrypt), otherwise 0 (decrypt).
- FSM states: IDLE, PASS1, PASS2, PASS3.
- IDLE with `start`=1:
  - latch `ciphertext` into `data_r`, and `key1`/`key2` into `key1_r`/`key2_r`;
  - clear `wait_cnt`; go to PASS1.
- IDLE with `start`=0: remain in IDLE.
- PASSn:
  - `wait_cnt` increments every cycle.
  - When `wait_cnt` == `PASS_WAIT`-1: load `data_r` with `des.out`, clear `wait_cnt`, advance PASS1→PASS2→PASS3.
  - At the end of PASS3: load `plaintext` with `des.out` (`data_r` may also be loaded), pulse `done`, go to IDLE.
- `wait_cnt` is 4 bits wide and wraps only via the explicit clear.
- `start` is ignored outside IDLE. Inputs changing while `busy` is high have no effect, because everything is latched.
- Reset, at any time including mid-operation:
  - state = IDLE; `wait_cnt`, `data_r`, `key1_r`, `key2_r` = 0;
  - `plaintext` = 0, `busy` = 0, `done` = 0;
  - an aborted block never produces `done`.
- Reset has priority over `start` in the same cycle.
- When key1 == key2, the result equals single-DES decryption with key1.

## Timing
- Let the `start` accept edge be at the end of cycle t.
- `busy` = 1 during cycles t+1 … t+3·`PASS_WAIT`. `busy` is a registered output (`state` != IDLE).
- `plaintext` is valid and `done` = 1 in cycle t+3·`PASS_WAIT`+1. `done` is high for exactly one cycle; `busy` = 0 in that cycle.
- Latency from start to done is 3·`PASS_WAIT`+1 cycles (4 cycles at default).
- Back-to-back: the FSM is in IDLE during the `done` cycle, so `start` is accepted there. Throughput is one block per 3·`PASS_WAIT`+1 cycles.
- `des` inputs come only from registers (`data_r`, `key*_r`, `state`). The `des` path is therefore a clean `PASS_WAIT`-cycle multicycle path, to be constrained as such.

## Test plan
- Reset, then idle 5 cycles → `plaintext` = 0, `busy` = 0, `done` = 0 throughout.
- key1 = key2 = 56'hF0CCAAF556678F (PC-1 form of 64'h133457799BBCDFF1), ciphertext 64'h85E813540F0AB405, `start` pulse, `PASS_WAIT`=1 → `done` at t+4 with `plaintext` 64'h0123456789ABCDEF; `busy` high t+1..t+3.
- Round trip with distinct key1/key2 (100 random blocks): encrypt with `tripledes` (or the golden model), decrypt here → `plaintext` equals the original block every time. Repeat with `PASS_WAIT`=3: `done` at t+10.
- `start` held high continuously with a new ciphertext each accept → accepts occur every 4 cycles (`PASS_WAIT`=1). `start` pulses and `ciphertext`/key changes while `busy` is high are ignored, and results match the latched inputs.
- `rst_n` low for one cycle during PASS2 → next cycle `busy` = 0, `plaintext` = 0, no `done`. A following `start` completes correctly after the full 4 cycles.
- `start` and `rst_n`=0 in the same cycle → stays IDLE, `busy` never rises.
